// File: rtl/alu_pkg.sv
// ============================================================================
// Package : alu_pkg
// Purpose : Shared ALU shift-path definitions: shift mode encodings and the
//           fill-bit helper used by the pipelined barrel shifter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  // Bit shifted into vacated positions. Only SRA replicates the sign bit;
  // ROR ignores it because wrapped bits fill the gap instead.
  function automatic logic shift_fill(input logic [1:0] mode, input logic msb);
    return (mode == SHIFT_SRA) ? msb : 1'b0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_layer.sv
// ============================================================================
// Module  : shift_layer
// Purpose : One combinational mux layer of the barrel shifter. Shifts or
//           rotates the operand by DIST positions when sel is set.
// Ports   : data    in  WIDTH  operand entering this layer
//           mode    in  2      shift mode (SLL/SRL/SRA/ROR)
//           fill    in  1      bit inserted into vacated positions
//           sel     in  1      apply this layer's shift distance
//           shifted out WIDTH  layer result
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_layer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       mode,
  input  logic             fill,
  input  logic             sel,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] moved;

  always_comb begin
    moved = data;
    case (mode)
      // fill is always 0 for SLL, so it doubles as the zero source
      SHIFT_SLL: moved = {data[WIDTH-DIST-1:0], {DIST{fill}}};
      SHIFT_ROR: moved = {data[DIST-1:0], data[WIDTH-1:DIST]};
      default:   moved = {{DIST{fill}}, data[WIDTH-1:DIST]};
    endcase
    shifted = sel ? moved : data;
  end

endmodule

`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
// ============================================================================
// Module  : pipelined_barrel_shifter
// Purpose : Pipelined WIDTH-bit barrel shifter (SLL, SRL, SRA, ROR) with one
//           register stage per mux layer and a valid/ready handshake.
//           Latency is LAYERS cycles, throughput one op per cycle; the whole
//           pipe stalls while the output is valid and not accepted.
// Ports   : clk        in   1        clock, rising edge
//           rst_n      in   1        asynchronous active-low reset
//           in_valid   in   1        data1/shamt/mode valid
//           in_ready   out  1        shifter accepts input this cycle
//           data1      in   WIDTH    operand
//           shamt      in   SHAMT_W  unsigned shift amount
//           mode       in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR
//           out_valid  out  1        result valid
//           out_ready  in   1        consumer accepts result
//           result     out  WIDTH    shifted value
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_barrel_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data1,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result
);

  localparam int LAYERS = $clog2(WIDTH);
  // The last stage only carries valid + final data; all earlier stages also
  // carry the per-op control that later layers still need.
  localparam int META   = LAYERS - 1;

  logic             stage_valid [LAYERS];
  logic [WIDTH-1:0] stage_data  [LAYERS];
  logic [1:0]       stage_mode  [META];
  logic             stage_fill  [META];
  logic             stage_ovr   [META];
  // Remaining shift-amount bits, pre-shifted so bit 0 always drives the
  // next layer's select.
  logic [LAYERS-1:0] stage_shamt [META];

  logic [WIDTH-1:0] layer_out [LAYERS];
  logic [WIDTH-1:0] final_data;
  logic             en;
  logic             in_fill;
  logic             in_ovr;

  assign en        = !stage_valid[LAYERS-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = stage_valid[LAYERS-1];
  assign result    = stage_data[LAYERS-1];

  assign in_fill = shift_fill(mode, data1[WIDTH-1]);

  // Any set bit above the layer-select range means the amount is >= WIDTH.
  always_comb begin
    in_ovr = 1'b0;
    for (int i = LAYERS; i < SHAMT_W; i++) begin
      in_ovr = in_ovr | shamt[i];
    end
  end

  for (genvar k = 0; k < LAYERS; k++) begin : g_layer
    if (k == 0) begin : g_first
      shift_layer #(
        .WIDTH (WIDTH),
        .DIST  (1)
      ) u_layer (
        .data    (data1),
        .mode    (mode),
        .fill    (in_fill),
        .sel     (shamt[0]),
        .shifted (layer_out[0])
      );
    end else begin : g_rest
      shift_layer #(
        .WIDTH (WIDTH),
        .DIST  (1 << k)
      ) u_layer (
        .data    (stage_data[k-1]),
        .mode    (stage_mode[k-1]),
        .fill    (stage_fill[k-1]),
        .sel     (stage_shamt[k-1][0]),
        .shifted (layer_out[k])
      );
    end
  end

  // Over-range override: logical shifts collapse to zero, SRA to the sign
  // (which is exactly the stored fill bit); ROR wraps modulo WIDTH.
  always_comb begin
    final_data = layer_out[LAYERS-1];
    if (stage_ovr[META-1] && (stage_mode[META-1] != SHIFT_ROR)) begin
      final_data = {WIDTH{stage_fill[META-1]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAYERS; k++) begin
        stage_valid[k] <= 1'b0;
        stage_data[k]  <= '0;
      end
      for (int k = 0; k < META; k++) begin
        stage_mode[k]  <= SHIFT_SLL;
        stage_fill[k]  <= 1'b0;
        stage_ovr[k]   <= 1'b0;
        stage_shamt[k] <= '0;
      end
    end else if (en) begin
      stage_valid[0] <= in_valid;
      stage_data[0]  <= layer_out[0];
      stage_mode[0]  <= mode;
      stage_fill[0]  <= in_fill;
      stage_ovr[0]   <= in_ovr;
      stage_shamt[0] <= shamt[LAYERS-1:0] >> 1;
      for (int k = 1; k < META; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        stage_data[k]  <= layer_out[k];
        stage_mode[k]  <= stage_mode[k-1];
        stage_fill[k]  <= stage_fill[k-1];
        stage_ovr[k]   <= stage_ovr[k-1];
        stage_shamt[k] <= stage_shamt[k-1] >> 1;
      end
      stage_valid[LAYERS-1] <= stage_valid[META-1];
      stage_data[LAYERS-1]  <= final_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
// ============================================================================
// Module  : tb_pipelined_barrel_shifter
// Purpose : Directed self-checking bench for pipelined_barrel_shifter
//           (WIDTH=8, SHAMT_W=8) with hand-computed expected results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_barrel_shifter;
  import alu_pkg::*;

  localparam int WIDTH   = 8;
  localparam int SHAMT_W = 8;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic               in_valid  = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   data1     = '0;
  logic [SHAMT_W-1:0] shamt     = '0;
  logic [1:0]         mode      = SHIFT_SLL;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [WIDTH-1:0]   result;

  int n_cmp   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int out_cnt = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         out_cyc[$];

  typedef struct {
    logic [1:0] m;
    logic [7:0] d;
    logic [7:0] s;
    logic [7:0] e;
  } vec_t;

  vec_t vecs[14] = '{
    '{SHIFT_SLL, 8'h0F, 8'd7,   8'h80},
    '{SHIFT_SRL, 8'hF0, 8'd2,   8'h3C},
    '{SHIFT_SRA, 8'h80, 8'd3,   8'hF0},
    '{SHIFT_SRA, 8'h40, 8'd3,   8'h08},
    '{SHIFT_SRL, 8'hFF, 8'd9,   8'h00},
    '{SHIFT_SRA, 8'h80, 8'd12,  8'hFF},
    '{SHIFT_ROR, 8'h81, 8'd9,   8'hC0},
    '{SHIFT_SLL, 8'h5A, 8'd0,   8'h5A},
    '{SHIFT_ROR, 8'h96, 8'd8,   8'h96},
    '{SHIFT_ROR, 8'h96, 8'd3,   8'hD2},
    '{SHIFT_SLL, 8'hFF, 8'd8,   8'h00},
    '{SHIFT_SRA, 8'h7F, 8'd200, 8'h00},
    '{SHIFT_SRL, 8'h80, 8'd7,   8'h01},
    '{SHIFT_SRA, 8'h81, 8'd7,   8'hFF}
  };

  pipelined_barrel_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data1     (data1),
    .shamt     (shamt),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output scoreboard: sample just after the falling edge, when both
  // out_valid and the bench-driven out_ready are settled for the next edge.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      out_cnt++;
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("spurious_output", 32'd1, 32'd0);
      else check(tag_q.pop_front(), {24'b0, result}, {24'b0, exp_q.pop_front()});
    end
  end

  // Present one op starting at a falling edge; returns at the falling edge
  // after the accepting rising edge with in_valid still high.
  task automatic send(input logic [1:0] m, input logic [7:0] d, input logic [7:0] s,
                      input logic [7:0] e, input string tag);
    int guard = 0;
    mode = m; data1 = d; shamt = s; in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    end else begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int span;
    int base;
    int seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", {24'b0, result}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Latency: accept cycle is cycle 0, result appears in cycle 3
    out_ready = 1'b1;
    send(SHIFT_SLL, 8'hAA, 8'd1, 8'h54, "sll_aa_1");
    in_valid = 1'b0;
    check("lat_cycle1", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_cycle2", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_cycle3", {31'b0, out_valid}, 32'd1);
    drain("lat");

    // Back-to-back stream of 8 ops
    out_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].m, vecs[i].d, vecs[i].s, vecs[i].e, $sformatf("vec%0d", i));
    end
    in_valid = 1'b0;
    drain("stream");
    check("stream_count", out_cyc.size(), 32'd8);
    span = (out_cyc.size() >= 8) ? (out_cyc[7] - out_cyc[0]) : -1;
    check("stream_span", span, 32'd7);

    // Remaining boundary vectors
    for (int i = 8; i < 14; i++) begin
      send(vecs[i].m, vecs[i].d, vecs[i].s, vecs[i].e, $sformatf("vec%0d", i));
    end
    in_valid = 1'b0;
    drain("bound");

    // Backpressure with a full pipe
    out_ready = 1'b0;
    send(SHIFT_SRL, 8'hF0, 8'd2, 8'h3C, "bp0");
    send(SHIFT_SRA, 8'h40, 8'd3, 8'h08, "bp1");
    send(SHIFT_ROR, 8'h81, 8'd9, 8'hC0, "bp2");
    mode = SHIFT_SLL; data1 = 8'h0F; shamt = 8'd7; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold", {24'b0, result}, 32'h3C);
      @(negedge clk);
    end
    base = out_cnt;
    exp_q.push_back(8'h80);
    tag_q.push_back("bp3");
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    drain("bp");
    check("bp_count", out_cnt - base, 32'd4);

    // Reset while two ops are in flight
    out_ready = 1'b0;
    send(SHIFT_SLL, 8'h33, 8'd2, 8'hCC, "rA");
    send(SHIFT_SRL, 8'h33, 8'd1, 8'h19, "rB");
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", {31'b0, out_valid}, 32'd0);
    check("rst_async_result", {24'b0, result}, 32'd0);
    exp_q.delete();
    tag_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("rst_no_stale", seen, 32'd0);
    send(SHIFT_SRA, 8'h80, 8'd3, 8'hF0, "post_rst");
    in_valid = 1'b0;
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
